// File: rtl/aurora_hls_nfc_tx_gate_pkg.sv
// Shared definitions for the TX-side NFC gate.
// Contents:
//   NFC_XOFF / NFC_XON : reserved NFC message words. The RX-side XON/XOFF
//                        generator uses the same values.
//   nfc_state_e        : gate FSM state encoding.
//   nfc_msg_e          : decoded class of an accepted NFC word.
//   nfc_decode()       : classifies one NFC word.
package aurora_hls_nfc_tx_gate_pkg;

  localparam logic [15:0] NFC_XOFF = 16'hFFFF;
  localparam logic [15:0] NFC_XON  = 16'h0000;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_XOFF  = 3'd3,
    ST_TIMED = 3'd4
  } nfc_state_e;

  typedef enum logic [1:0] {
    MSG_NONE  = 2'd0,
    MSG_XON   = 2'd1,
    MSG_XOFF  = 2'd2,
    MSG_TIMED = 2'd3
  } nfc_msg_e;

  // Any word other than the two reserved values is a timed pause of that
  // many cycles.
  function automatic nfc_msg_e nfc_decode(input logic accept, input logic [15:0] word);
    nfc_msg_e kind;
    if (!accept)               kind = MSG_NONE;
    else if (word == NFC_XOFF) kind = MSG_XOFF;
    else if (word == NFC_XON)  kind = MSG_XON;
    else                       kind = MSG_TIMED;
    return kind;
  endfunction

endpackage

// File: rtl/aurora_hls_nfc_pause_timer.sv
// Load / decrement pause timer.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (count cleared)
//   load        : load load_value; this takes priority over counting
//   load_value  : number of cycles to hold
//   run         : decrement once per cycle while the owner is in its wait state
//   done        : high during the last cycle of the hold (count == 1 while running)
// Load N on the accepting edge and done rises in the N-th running cycle.
// The owner can therefore leave its wait state after exactly N cycles.
module aurora_hls_nfc_pause_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = run && (count == WIDTH'(1));

endmodule

// File: rtl/aurora_hls_nfc_tx_gate.sv
// TX-side Native Flow Control gate.
// This block decodes NFC words sent by the link partner. It throttles the
// user TX AXI-Stream between the HLS kernel and the Aurora core. A pause
// can be deferred to the end of the current frame, so frames are never split.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   counter_reset       : clears the four counters; FSM state is untouched
//   nfc_rx_*            : NFC message input (FFFF=XOFF, 0000=XON, N=pause N cycles)
//   s_axis_*            : user TX stream in
//   m_axis_*            : TX stream out to the Aurora core (zero-latency pass-through)
//   xoff_count          : accepted XOFF messages
//   timed_count         : accepted timed-pause messages
//   stall_count         : cycles with the gate closed while s_axis_tvalid=1
//   timeout_count       : XOFF auto-resume events
module aurora_hls_nfc_tx_gate
  import aurora_hls_nfc_tx_gate_pkg::*;
#(
  parameter int          DATA_WIDTH    = 256,
  parameter bit          FRAME_ALIGNED = 1'b1,
  parameter int unsigned XOFF_TIMEOUT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    counter_reset,
  input  logic                    nfc_rx_tvalid,
  output logic                    nfc_rx_tready,
  input  logic [0:15]             nfc_rx_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [31:0]             xoff_count,
  output logic [31:0]             timed_count,
  output logic [31:0]             stall_count,
  output logic [31:0]             timeout_count
);

  localparam logic [31:0] TIMEOUT_LOAD = 32'(XOFF_TIMEOUT);
  localparam bit          TIMEOUT_EN   = (XOFF_TIMEOUT != 0);

  nfc_state_e  state;
  nfc_state_e  state_next;
  nfc_msg_e    msg;
  nfc_msg_e    pend_kind;
  nfc_msg_e    pend_kind_next;
  logic [15:0] pend_n;
  logic [15:0] pend_n_next;
  logic [15:0] nfc_word;

  logic        gate;
  logic        accept;
  logic        beat;
  logic        tlast_beat;
  logic        in_frame;
  logic        frame_open;

  logic        timed_load;
  logic [15:0] timed_load_value;
  logic        timed_done;
  logic        xoff_load;
  logic        xoff_done;
  logic        timeout_hit;

  // Zero-latency data path; only the handshakes see the gate.
  assign m_axis_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = m_axis_tready & gate;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign nfc_word   = nfc_rx_tdata;
  assign accept     = nfc_rx_tvalid & nfc_rx_tready;
  assign msg        = nfc_decode(accept, nfc_word);
  assign beat       = s_axis_tvalid & s_axis_tready;
  assign tlast_beat = beat & s_axis_tlast;
  // This cycle's beat decides whether a pause that arrives now must wait
  // for a tlast.
  assign frame_open = beat ? ~s_axis_tlast : in_frame;

  aurora_hls_nfc_pause_timer #(.WIDTH(16)) u_timed_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timed_load),
    .load_value (timed_load_value),
    .run        (state == ST_TIMED),
    .done       (timed_done)
  );

  aurora_hls_nfc_pause_timer #(.WIDTH(32)) u_xoff_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (xoff_load),
    .load_value (TIMEOUT_LOAD),
    .run        (state == ST_XOFF),
    .done       (xoff_done)
  );

  // State register and pending-pause storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RESET;
      pend_kind <= MSG_NONE;
      in_frame  <= 1'b0;
    end else begin
      state     <= state_next;
      pend_kind <= pend_kind_next;
      if (beat) begin
        in_frame <= ~s_axis_tlast;
      end
    end
  end

  always_ff @(posedge clk) begin
    pend_n <= pend_n_next;
  end

  // Next-state logic. An accepted message always beats a timer expiry
  // or a tlast in the same cycle.
  always_comb begin
    state_next       = state;
    pend_kind_next   = pend_kind;
    pend_n_next      = pend_n;
    timed_load       = 1'b0;
    timed_load_value = nfc_word;
    xoff_load        = 1'b0;
    timeout_hit      = 1'b0;
    case (state)
      ST_RESET: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if ((msg == MSG_XOFF) || (msg == MSG_TIMED)) begin
          if (FRAME_ALIGNED && frame_open) begin
            state_next     = ST_DRAIN;
            pend_kind_next = msg;
            pend_n_next    = nfc_word;
          end else if (msg == MSG_XOFF) begin
            state_next = ST_XOFF;
            xoff_load  = 1'b1;
          end else begin
            state_next = ST_TIMED;
            timed_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (msg == MSG_XON) begin
          state_next     = ST_RUN;
          pend_kind_next = MSG_NONE;
        end else if ((msg == MSG_XOFF) && tlast_beat) begin
          state_next = ST_XOFF;
          xoff_load  = 1'b1;
        end else if ((msg == MSG_TIMED) && tlast_beat) begin
          state_next = ST_TIMED;
          timed_load = 1'b1;
        end else if ((msg == MSG_XOFF) || (msg == MSG_TIMED)) begin
          pend_kind_next = msg;
          pend_n_next    = nfc_word;
        end else if (tlast_beat) begin
          if (pend_kind == MSG_TIMED) begin
            state_next       = ST_TIMED;
            timed_load       = 1'b1;
            timed_load_value = pend_n;
          end else begin
            state_next = ST_XOFF;
            xoff_load  = 1'b1;
          end
        end
      end
      ST_XOFF: begin
        if (msg == MSG_XON) begin
          state_next = ST_RUN;
        end else if (msg == MSG_TIMED) begin
          state_next = ST_TIMED;
          timed_load = 1'b1;
        end else if (msg == MSG_XOFF) begin
          xoff_load = 1'b1;
        end else if (TIMEOUT_EN && xoff_done) begin
          state_next  = ST_RUN;
          timeout_hit = 1'b1;
        end
      end
      ST_TIMED: begin
        if (msg == MSG_XON) begin
          state_next = ST_RUN;
        end else if (msg == MSG_XOFF) begin
          state_next = ST_XOFF;
          xoff_load  = 1'b1;
        end else if (msg == MSG_TIMED) begin
          timed_load = 1'b1;
        end else if (timed_done) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // Output decode
  always_comb begin
    gate          = (state == ST_RUN) || (state == ST_DRAIN);
    nfc_rx_tready = ~rst && (state != ST_RESET);
  end

  // Event counters; counter_reset wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || counter_reset) begin
      xoff_count    <= '0;
      timed_count   <= '0;
      stall_count   <= '0;
      timeout_count <= '0;
    end else begin
      if (msg == MSG_XOFF)        xoff_count    <= xoff_count + 32'd1;
      if (msg == MSG_TIMED)       timed_count   <= timed_count + 32'd1;
      if (!gate && s_axis_tvalid) stall_count   <= stall_count + 32'd1;
      if (timeout_hit)            timeout_count <= timeout_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_aurora_hls_nfc_tx_gate.sv
module tb_aurora_hls_nfc_tx_gate;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          counter_reset;
  logic          nfc_rx_tvalid;
  logic          nfc_rx_tready;
  logic [0:15]   nfc_rx_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [DW/8-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [31:0]   xoff_count;
  logic [31:0]   timed_count;
  logic [31:0]   stall_count;
  logic [31:0]   timeout_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aurora_hls_nfc_tx_gate #(
    .DATA_WIDTH    (DW),
    .FRAME_ALIGNED (1'b1),
    .XOFF_TIMEOUT  (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .counter_reset (counter_reset),
    .nfc_rx_tvalid (nfc_rx_tvalid),
    .nfc_rx_tready (nfc_rx_tready),
    .nfc_rx_tdata  (nfc_rx_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .xoff_count    (xoff_count),
    .timed_count   (timed_count),
    .stall_count   (stall_count),
    .timeout_count (timeout_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_msg(input logic [15:0] word);
    nfc_rx_tvalid = 1'b1;
    nfc_rx_tdata  = word;
    step();
    nfc_rx_tvalid = 1'b0;
  endtask

  task automatic clr_counters();
    counter_reset = 1'b1;
    step();
    counter_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    counter_reset = 1'b0;
    nfc_rx_tvalid = 1'b0;
    nfc_rx_tdata  = 16'h0000;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset and the RESET -> RUN transition
    step();
    step();
    #1;
    chk("rst_nfc_rdy", 32'(nfc_rx_tready), 32'd0);
    chk("rst_xoff_cnt", xoff_count, 32'd0);
    chk("rst_stall_cnt", stall_count, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_state_gate", 32'(s_axis_tready), 32'd0);
    chk("reset_state_rdy", 32'(nfc_rx_tready), 32'd0);
    step();
    #1;
    chk("run_gate", 32'(s_axis_tready), 32'd1);
    chk("run_rdy", 32'(nfc_rx_tready), 32'd1);

    // Test 1: XOFF on an idle stream, backlog stalls, XON 20 cycles later
    s_axis_tlast = 1'b1;
    send_msg(16'hFFFF);
    s_axis_tvalid = 1'b1;
    #1;
    chk("t1_gate_closed", 32'(m_axis_tvalid), 32'd0);
    chk("t1_xoff_cnt", xoff_count, 32'd1);
    repeat (19) step();
    #1;
    chk("t1_still_closed", 32'(s_axis_tready), 32'd0);
    chk("t1_rdy_in_xoff", 32'(nfc_rx_tready), 32'd1);
    send_msg(16'h0000);
    #1;
    chk("t1_flow", 32'(m_axis_tvalid), 32'd1);
    chk("t1_stall_cnt", stall_count, 32'd20);
    s_axis_tvalid = 1'b0;
    step();

    // Test 2: frame-aligned XOFF at beat 3 of an 8-beat frame
    clr_counters();
    s_axis_tvalid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_axis_tdata  = DW'(k);
      s_axis_tlast  = (k == 8);
      nfc_rx_tvalid = (k == 3);
      nfc_rx_tdata  = 16'hFFFF;
      #1;
      chk("t2_beat_vld", 32'(m_axis_tvalid), 32'd1);
      chk("t2_beat_data", m_axis_tdata, 32'(k));
      chk("t2_beat_last", 32'(m_axis_tlast), 32'(k == 8));
      step();
    end
    nfc_rx_tvalid = 1'b0;
    s_axis_tdata  = 32'd9;
    s_axis_tlast  = 1'b0;
    #1;
    chk("t2_closed_after_last", 32'(m_axis_tvalid), 32'd0);
    chk("t2_xoff_cnt", xoff_count, 32'd1);
    step();
    step();
    #1;
    chk("t2_next_frame_held", 32'(m_axis_tvalid), 32'd0);
    s_axis_tvalid = 1'b0;
    send_msg(16'h0000);

    // Test 3a: N=5 on an idle link
    clr_counters();
    send_msg(16'd5);
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk("t3_gate_n5", 32'(s_axis_tready), 32'(i == 6));
      step();
    end
    chk("t3_timed_cnt", timed_count, 32'd1);

    // Test 3b: N=5, then N=3 two cycles later -> 5 closed cycles total
    send_msg(16'd5);
    #1;
    chk("t3_reload_c1", 32'(s_axis_tready), 32'd0);
    step();
    #1;
    chk("t3_reload_c2", 32'(s_axis_tready), 32'd0);
    send_msg(16'd3);
    for (int i = 3; i <= 6; i++) begin
      #1;
      chk("t3_gate_reload", 32'(s_axis_tready), 32'(i == 6));
      step();
    end
    chk("t3_timed_cnt2", timed_count, 32'd3);

    // Test 4: XOFF with no XON -> auto-resume after 100 cycles
    clr_counters();
    send_msg(16'hFFFF);
    repeat (99) step();
    #1;
    chk("t4_closed_c100", 32'(s_axis_tready), 32'd0);
    chk("t4_timeout_cnt0", timeout_count, 32'd0);
    step();
    #1;
    chk("t4_open_c101", 32'(s_axis_tready), 32'd1);
    chk("t4_timeout_cnt", timeout_count, 32'd1);
    chk("t4_xoff_cnt", xoff_count, 32'd1);

    // Test 5: rst while paused mid-frame
    clr_counters();
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 32'd1;
    step();
    s_axis_tdata = 32'd2;
    send_msg(16'hFFFF);
    s_axis_tvalid = 1'b0;
    #1;
    chk("t5_drain_open", 32'(s_axis_tready), 32'd1);
    chk("t5_xoff_cnt", xoff_count, 32'd1);
    rst = 1'b1;
    step();
    #1;
    chk("t5_rst_rdy", 32'(nfc_rx_tready), 32'd0);
    chk("t5_rst_xoff_cnt", xoff_count, 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_reset_state", 32'(s_axis_tready), 32'd0);
    step();
    #1;
    chk("t5_run", 32'(s_axis_tready), 32'd1);
    send_msg(16'hFFFF);
    #1;
    chk("t5_inframe_cleared", 32'(s_axis_tready), 32'd0);
    send_msg(16'h0000);
    for (int k = 1; k <= 3; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(k + 16);
      s_axis_tlast  = (k == 3);
      #1;
      chk("t5_frame_vld", 32'(m_axis_tvalid), 32'd1);
      chk("t5_frame_last", 32'(m_axis_tlast), 32'(k == 3));
      step();
    end
    s_axis_tvalid = 1'b0;

    // Test 6a: XON during DRAIN cancels the pending pause
    clr_counters();
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 32'd1;
    send_msg(16'hFFFF);
    s_axis_tdata  = 32'd2;
    nfc_rx_tvalid = 1'b1;
    nfc_rx_tdata  = 16'h0000;
    #1;
    chk("t6_drain_vld", 32'(m_axis_tvalid), 32'd1);
    step();
    nfc_rx_tvalid = 1'b0;
    s_axis_tdata  = 32'd3;
    s_axis_tlast  = 1'b1;
    #1;
    chk("t6_tlast_vld", 32'(m_axis_tvalid), 32'd1);
    step();
    s_axis_tdata = 32'd4;
    #1;
    chk("t6_no_pause", 32'(m_axis_tvalid), 32'd1);
    step();
    #1;
    chk("t6_no_pause2", 32'(m_axis_tvalid), 32'd1);

    // Test 6b: XOFF with tlast in DRAIN overrides the pending N=4
    s_axis_tlast = 1'b0;
    s_axis_tdata = 32'd5;
    send_msg(16'd4);
    s_axis_tlast  = 1'b1;
    s_axis_tdata  = 32'd6;
    nfc_rx_tvalid = 1'b1;
    nfc_rx_tdata  = 16'hFFFF;
    #1;
    chk("t6_collide_vld", 32'(m_axis_tvalid), 32'd1);
    step();
    nfc_rx_tvalid = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (5) step();
    #1;
    chk("t6_xoff_wins", 32'(s_axis_tready), 32'd0);
    chk("t6_timed_cnt", timed_count, 32'd1);
    chk("t6_xoff_cnt", xoff_count, 32'd2);
    send_msg(16'h0000);

    // Test 6c: counter_reset in the same cycle as an XOFF accept
    counter_reset = 1'b1;
    send_msg(16'hFFFF);
    counter_reset = 1'b0;
    #1;
    chk("t6_cr_xoff_cnt", xoff_count, 32'd0);
    chk("t6_cr_state", 32'(s_axis_tready), 32'd0);
    send_msg(16'h0000);
    #1;
    chk("t6_final_open", 32'(s_axis_tready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
